alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
Parameters
REQ-001 SHALL provide parameter RV, default 64: datapath width; legal values 32 or 64.
REQ-002 SHALL provide parameter STEP, default 8: multiplier bits consumed per iteration; legal values 1, 2, 4 or 8.
REQ-003 SHALL provide parameters NHART=1, LNHART=0, NCOMMIT=32, LNCOMMIT=5 and CNTRL_SIZE=7.

Ports
REQ-004 SHALL provide these ports:
- clk  in  1  sole clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  issue strobe.
- control  in  CNTRL_SIZE  op select: [2:0] op, [3] inv, [4] addw.
- rd  in  LNCOMMIT  destination commit tag.
- makes_rd  in  1  op writes rd.
- needs_rs2  in  1  1 = use r2, 0 = use sign-extended immed.
- r1, r2  in  RV  operands.
- immed  in  32  immediate.
- hart  in  max(LNHART,1)  issuing hart.
- rv32  in  1  hart is in 32-bit mode.
- commit_kill  in  NHART*NCOMMIT  per-hart kill vector, indexed hart*NCOMMIT+rd.
- busy  out  1  iterative op in flight; upstream holds issue.
- result  out  RV  result.
- res_rd  out  LNCOMMIT  tag of result.
- res_makes_rd  out  NHART  one-hot by hart; pulses one cycle with the result.

Function
REQ-005 SHALL define op encoding: 0 add, 1 xor, 2 and, 3 or, 4 slt, 5 sltu, 6 clmul (low RV bits of the carry-less product), 7 clmulh (high RV bits of the 2*RV-bit carry-less product).
REQ-006 SHALL accept an issue at cycle T only when enable=1 and busy=0; an issue while busy=1 SHALL be ignored and flagged by a simulation assertion.
REQ-007 SHALL, for ops 0-5, register operands at T+1 and present result, res_rd and the res_makes_rd pulse at T+2 (fully pipelined, one op per cycle).
REQ-008 SHALL, when inv=1, invert operand 2 and add carry-in 1; slt/sltu SHALL use the adder borrow/overflow, giving a zero-extended 0/1 result.
REQ-009 SHALL, when addw=1 and RV=64, sign-extend add result bit 31 to 64 bits.
REQ-010 SHALL run ops 6/7 through a state machine with states IDLE, RUN and DONE:
- IDLE->RUN at T+1; iteration count N = RV/STEP, or 32/STEP when rv32=1 or addw=1.
- RUN: each cycle XOR-accumulate r1 shifted by each set bit of the next STEP multiplier bits, LSB first, into a 2*RV-bit accumulator; decrement count; after N cycles go to DONE.
- DONE: drive result for one cycle, then IDLE.
REQ-011 SHALL give iterative latency L = N+2: result at T+L; busy=1 for T+1..T+L-1; next issue accepted at T+L.
REQ-012 SHALL, in 32-bit mode, zero-extend operand bits [31:0] and return clmul product[31:0] or clmulh product[63:32], sign-extended to RV.
REQ-013 SHALL sample commit_kill[hart*NCOMMIT+rd] every cycle an op is pending. A kill in RUN or DONE SHALL return the FSM to IDLE next cycle, deassert busy and suppress res_makes_rd. A kill at T+1 of a single-cycle op SHALL suppress its pulse.
REQ-014 SHALL hold result and res_rd at their last values when res_makes_rd=0.
REQ-015 SHALL let a single-cycle op issued at cycle X and an iterative result due at X+2 never coincide; this is guaranteed by busy, and a collision SHALL be asserted.

Reset
REQ-016 SHALL, on a cycle where reset=0, force FSM=IDLE, busy=0, res_makes_rd=0, result=0, res_rd=0, and discard all in-flight ops including mid-RUN.
REQ-017 SHALL accept the first issue on the first cycle after reset returns to 1.

Verification (RV=64, STEP=8, NHART=1)
REQ-018 add r1=5, r2=3 at T -> T+2: result=8, res_makes_rd=1, res_rd=rd; sub (inv=1) r1=3, r2=5 -> 0xFFFF_FFFF_FFFF_FFFE.
REQ-019 slt r1=-1, r2=1 -> 1; sltu same operands -> 0; addw r1=0x7FFF_FFFF, immed=1 -> 0xFFFF_FFFF_8000_0000.
REQ-020 clmul r1=3, r2=3 at T -> busy T+1..T+9, result=5 at T+10; back-to-back add issued at T+10 -> result at T+12.
REQ-021 clmulh r1=r2=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000 at T+10; same op with rv32=1, operands 0x8000_0000 -> 0x4000_0000 at T+6.
REQ-022 clmul issued, commit_kill[rd]=1 at T+4 -> busy=0 at T+5, no res_makes_rd through T+12.
REQ-023 reset=0 at T+3 during clmul -> busy=0 and result=0 at T+4, no pulse; new add at T+5 -> result at T+7.

Source files
------------

// File: rtl/alu_mc_if.sv
// ----------------------------------------------------------------------------
// alu_mc_if
// Issue / result bundle between an issue stage (master) and the multi-cycle
// ALU (slave).
//
// Issue side (master -> slave):
//   enable       issue strobe
//   control      [2:0] op, [3] inv, [4] addw
//   rd           destination commit tag
//   makes_rd     op writes rd
//   needs_rs2    1 = use r2, 0 = use sign-extended immed
//   r1, r2       operands
//   immed        32-bit immediate
//   hart         issuing hart
//   rv32         issuing hart runs in 32-bit mode
//   commit_kill  per-hart kill vector, indexed hart*NCOMMIT+rd
// Result side (slave -> master):
//   busy         iterative op in flight, hold issue
//   result       result value, held when no pulse
//   res_rd       tag of result
//   res_makes_rd one-hot by hart, one-cycle pulse with the result
// ----------------------------------------------------------------------------
interface alu_mc_if #(
    parameter int RV         = 64,
    parameter int NHART      = 1,
    parameter int LNHART     = 0,
    parameter int NCOMMIT    = 32,
    parameter int LNCOMMIT   = 5,
    parameter int CNTRL_SIZE = 7
);
    localparam int HW = (LNHART > 0) ? LNHART : 1;

    logic                     enable;
    logic [CNTRL_SIZE-1:0]    control;
    logic [LNCOMMIT-1:0]      rd;
    logic                     makes_rd;
    logic                     needs_rs2;
    logic [RV-1:0]            r1;
    logic [RV-1:0]            r2;
    logic [31:0]              immed;
    logic [HW-1:0]            hart;
    logic                     rv32;
    logic [NHART*NCOMMIT-1:0] commit_kill;
    logic                     busy;
    logic [RV-1:0]            result;
    logic [LNCOMMIT-1:0]      res_rd;
    logic [NHART-1:0]         res_makes_rd;

    modport master (
        output enable, control, rd, makes_rd, needs_rs2, r1, r2, immed,
               hart, rv32, commit_kill,
        input  busy, result, res_rd, res_makes_rd
    );

    modport slave (
        input  enable, control, rd, makes_rd, needs_rs2, r1, r2, immed,
               hart, rv32, commit_kill,
        output busy, result, res_rd, res_makes_rd
    );
endinterface

// File: rtl/alu_mc.sv
// ----------------------------------------------------------------------------
// alu_mc
// Integer ALU with a two-stage single-cycle path (add/sub, xor, and, or,
// slt, sltu) and an iterative carry-less multiplier (clmul, clmulh) that
// consumes STEP multiplier bits per cycle.
//
// Ports:
//   clk    sole clock, all state on the rising edge
//   reset  synchronous, active-low reset
//   bus    alu_mc_if slave modport (issue inputs, result outputs)
//
// Single-cycle ops: issue at T, operands registered at T+1, result and
// res_makes_rd pulse at T+2. Iterative ops: IDLE -> RUN (N cycles) -> DONE,
// result at T+N+2, busy held from T+1 to T+N+1.
// ----------------------------------------------------------------------------
module alu_mc #(
    parameter int RV         = 64,
    parameter int STEP       = 8,
    parameter int NHART      = 1,
    parameter int LNHART     = 0,
    parameter int NCOMMIT    = 32,
    parameter int LNCOMMIT   = 5,
    parameter int CNTRL_SIZE = 7
) (
    input logic   clk,
    input logic   reset,
    alu_mc_if.slave bus
);

    localparam int HW = (LNHART > 0) ? LNHART : 1;
    localparam int CW = $clog2(RV + 1);
    localparam logic [CW-1:0] NFULL = CW'(RV / STEP);
    localparam logic [CW-1:0] NHALF = CW'(32 / STEP);

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_XOR    = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_OR     = 3'd3;
    localparam logic [2:0] OP_SLT    = 3'd4;
    localparam logic [2:0] OP_SLTU   = 3'd5;
    localparam logic [2:0] OP_CLMUL  = 3'd6;
    localparam logic [2:0] OP_CLMULH = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [RV-1:0] sext32(input logic [31:0] v);
        return RV'($signed(v));
    endfunction

    // Select commit_kill[h*NCOMMIT+r] without a wide computed index.
    function automatic logic killLookup(
        input logic [NHART*NCOMMIT-1:0] kv,
        input logic [HW-1:0]            h,
        input logic [LNCOMMIT-1:0]      r
    );
        logic k;
        k = 1'b0;
        for (int i = 0; i < NHART; i++) begin
            for (int j = 0; j < NCOMMIT; j++) begin
                if (h == HW'(i) && r == LNCOMMIT'(j)) begin
                    k = kv[i*NCOMMIT+j];
                end
            end
        end
        return k;
    endfunction

    // Issue decode
    logic          issue;
    logic [2:0]    inOp;
    logic          inIter;
    logic          inW32;
    logic [RV-1:0] inB;
    logic          busy;
    logic          unusedCtrl;

    // Single-cycle stage registers
    logic                s1Valid_q;
    logic [2:0]          s1Op_q;
    logic                s1Inv_q;
    logic                s1Addw_q;
    logic                s1MakesRd_q;
    logic [LNCOMMIT-1:0] s1Rd_q;
    logic [HW-1:0]       s1Hart_q;
    logic [RV-1:0]       s1A_q;
    logic [RV-1:0]       s1B_q;

    logic          s1Sub;
    logic [RV-1:0] s1BEff;
    logic [RV:0]   s1Sum;
    logic [RV-1:0] s1AddRes;
    logic          s1Ovf;
    logic [RV-1:0] s1Result;
    logic          s1Kill;
    logic          s1Fire;

    // Iterative multiplier state
    state_e              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*RV-1:0]     mcand_q, mcand_d;
    logic [RV-1:0]       mplier_q, mplier_d;
    logic [2*RV-1:0]     acc_q, acc_d;
    logic                itHigh_q, itHigh_d;
    logic                itW32_q, itW32_d;
    logic                itMakesRd_q, itMakesRd_d;
    logic [LNCOMMIT-1:0] itRd_q, itRd_d;
    logic [HW-1:0]       itHart_q, itHart_d;
    logic [2*RV-1:0]     partial;
    logic                itKill;

    logic [31:0]   sel32;
    logic [RV-1:0] iterResult;
    logic          iterFire;

    // Result registers
    logic [RV-1:0]       result_q;
    logic [LNCOMMIT-1:0] resRd_q;
    logic [NHART-1:0]    resPulse_q;
    logic [RV-1:0]       resultNext;
    logic [LNCOMMIT-1:0] rdNext;
    logic [HW-1:0]       hartNext;
    logic [NHART-1:0]    pulseNext;

    assign unusedCtrl = ^bus.control[CNTRL_SIZE-1:5];

    // Decode the incoming issue; an issue is only taken while not busy.
    always_comb begin
        issue  = bus.enable && !busy;
        inOp   = bus.control[2:0];
        inIter = (inOp == OP_CLMUL) || (inOp == OP_CLMULH);
        inW32  = bus.rv32 || bus.control[4];
        inB    = bus.needs_rs2 ? bus.r2 : sext32(bus.immed);
    end

    // Operand register for the single-cycle path.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1Valid_q   <= 1'b0;
            s1Op_q      <= '0;
            s1Inv_q     <= 1'b0;
            s1Addw_q    <= 1'b0;
            s1MakesRd_q <= 1'b0;
            s1Rd_q      <= '0;
            s1Hart_q    <= '0;
            s1A_q       <= '0;
            s1B_q       <= '0;
        end else begin
            s1Valid_q <= issue && !inIter;
            if (issue && !inIter) begin
                s1Op_q      <= inOp;
                s1Inv_q     <= bus.control[3];
                s1Addw_q    <= bus.control[4];
                s1MakesRd_q <= bus.makes_rd;
                s1Rd_q      <= bus.rd;
                s1Hart_q    <= bus.hart;
                s1A_q       <= bus.r1;
                s1B_q       <= inB;
            end
        end
    end

    // Single-cycle execute. Compares always subtract so they get a borrow
    // and overflow from the shared adder regardless of the inv bit.
    always_comb begin
        s1Sub    = s1Inv_q || (s1Op_q == OP_SLT) || (s1Op_q == OP_SLTU);
        s1BEff   = s1Sub ? ~s1B_q : s1B_q;
        s1Sum    = {1'b0, s1A_q} + {1'b0, s1BEff} + (RV+1)'(s1Sub);
        s1AddRes = (s1Addw_q && RV == 64) ? sext32(s1Sum[31:0]) : s1Sum[RV-1:0];
        s1Ovf    = (s1A_q[RV-1] == s1BEff[RV-1]) && (s1Sum[RV-1] != s1A_q[RV-1]);
        case (s1Op_q)
            OP_ADD:  s1Result = s1AddRes;
            OP_XOR:  s1Result = s1A_q ^ s1BEff;
            OP_AND:  s1Result = s1A_q & s1BEff;
            OP_OR:   s1Result = s1A_q | s1BEff;
            OP_SLT:  s1Result = {{(RV-1){1'b0}}, s1Sum[RV-1] ^ s1Ovf};
            OP_SLTU: s1Result = {{(RV-1){1'b0}}, ~s1Sum[RV]};
            default: s1Result = '0;
        endcase
        s1Kill = killLookup(bus.commit_kill, s1Hart_q, s1Rd_q);
        s1Fire = s1Valid_q && s1MakesRd_q && !s1Kill;
    end

    // Multiplier FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            itHigh_q    <= 1'b0;
            itW32_q     <= 1'b0;
            itMakesRd_q <= 1'b0;
            itRd_q      <= '0;
            itHart_q    <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            itHigh_q    <= itHigh_d;
            itW32_q     <= itW32_d;
            itMakesRd_q <= itMakesRd_d;
            itRd_q      <= itRd_d;
            itHart_q    <= itHart_d;
        end
    end

    // Multiplier FSM next state. The multiplicand shifts left and the
    // multiplier shifts right by STEP each RUN cycle, so the low STEP
    // multiplier bits always line up with the current multiplicand.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        itHigh_d    = itHigh_q;
        itW32_d     = itW32_q;
        itMakesRd_d = itMakesRd_q;
        itRd_d      = itRd_q;
        itHart_d    = itHart_q;
        partial     = '0;
        itKill      = killLookup(bus.commit_kill, itHart_q, itRd_q);

        for (int j = 0; j < STEP; j++) begin
            if (mplier_q[j]) begin
                partial = partial ^ (mcand_q << j);
            end
        end

        case (state_q)
            IDLE: begin
                if (issue && inIter) begin
                    state_d     = RUN;
                    count_d     = inW32 ? NHALF : NFULL;
                    mcand_d     = inW32 ? (2*RV)'(bus.r1[31:0]) : (2*RV)'(bus.r1);
                    mplier_d    = inW32 ? RV'(inB[31:0]) : inB;
                    acc_d       = '0;
                    itHigh_d    = inOp[0];
                    itW32_d     = inW32;
                    itMakesRd_d = bus.makes_rd;
                    itRd_d      = bus.rd;
                    itHart_d    = bus.hart;
                end
            end
            RUN: begin
                acc_d    = acc_q ^ partial;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_q >> STEP;
                count_d  = count_q - CW'(1);
                if (itKill) begin
                    state_d = IDLE;
                end else if (count_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Multiplier FSM outputs and result arbitration. busy guarantees the
    // single-cycle and iterative results never fire together.
    always_comb begin
        busy  = (state_q != IDLE);
        sel32 = itHigh_q ? acc_q[63:32] : acc_q[31:0];
        if (itW32_q) begin
            iterResult = sext32(sel32);
        end else begin
            iterResult = itHigh_q ? acc_q[2*RV-1:RV] : acc_q[RV-1:0];
        end
        iterFire = (state_q == DONE) && itMakesRd_q && !itKill;

        resultNext = iterFire ? iterResult : s1Result;
        rdNext     = iterFire ? itRd_q : s1Rd_q;
        hartNext   = iterFire ? itHart_q : s1Hart_q;
        pulseNext  = '0;
        for (int i = 0; i < NHART; i++) begin
            if ((s1Fire || iterFire) && hartNext == HW'(i)) begin
                pulseNext[i] = 1'b1;
            end
        end
    end

    // Result registers hold their value between pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q   <= '0;
            resRd_q    <= '0;
            resPulse_q <= '0;
        end else begin
            resPulse_q <= pulseNext;
            if (s1Fire || iterFire) begin
                result_q <= resultNext;
                resRd_q  <= rdNext;
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.result       = result_q;
    assign bus.res_rd       = resRd_q;
    assign bus.res_makes_rd = resPulse_q;

    // Upstream must hold issue while busy.
    issueWhileBusy: assert property (@(posedge clk) disable iff (!reset)
        !(bus.enable && busy));

    // Single-cycle and iterative results must never collide.
    resultCollision: assert property (@(posedge clk) disable iff (!reset)
        !(s1Valid_q && state_q == DONE));

endmodule

// File: tb/tb_alu_mc.sv
// ----------------------------------------------------------------------------
// tb_alu_mc
// Directed self-checking bench for alu_mc (RV=64, STEP=8, NHART=1).
// ----------------------------------------------------------------------------
module tb_alu_mc;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_mc_if #(.RV(64), .NHART(1), .LNHART(0), .NCOMMIT(32), .LNCOMMIT(5),
                .CNTRL_SIZE(7)) bus ();

    alu_mc #(.RV(64), .STEP(8), .NHART(1), .LNHART(0), .NCOMMIT(32),
             .LNCOMMIT(5), .CNTRL_SIZE(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Step to 1 ns after the next rising edge (the next cycle).
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic driveOp(input logic [2:0] op, input logic inv, input logic addw,
                           input logic [4:0] rd, input logic needsRs2,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [31:0] imm, input logic w32);
        bus.enable    = 1'b1;
        bus.control   = {2'b00, addw, inv, op};
        bus.rd        = rd;
        bus.makes_rd  = 1'b1;
        bus.needs_rs2 = needsRs2;
        bus.r1        = a;
        bus.r2        = b;
        bus.immed     = imm;
        bus.rv32      = w32;
        bus.hart      = 1'b0;
    endtask

    task automatic driveIdle();
        bus.enable = 1'b0;
        bus.r1     = '0;
        bus.r2     = '0;
        bus.immed  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        driveIdle();
        bus.control     = '0;
        bus.rd          = '0;
        bus.makes_rd    = 1'b0;
        bus.needs_rs2   = 1'b1;
        bus.hart        = 1'b0;
        bus.rv32        = 1'b0;
        bus.commit_kill = '0;
        repeat (3) nextCycle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); end
        checks++; if (bus.result !== 64'd0) begin errors++; $display("[TB] FAIL reset result: got %h expected 0", bus.result); end
        checks++; if (bus.res_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset res_rd: got %0d expected 0", bus.res_rd); end
        checks++; if (bus.res_makes_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset pulse: got %b expected 0", bus.res_makes_rd); end
        // First cycle with reset released accepts an issue.
        reset = 1'b1;
        driveOp(3'd0, 1'b0, 1'b0, 5'd1, 1'b1, 64'd1, 64'd1, 32'd0, 1'b0);
        nextCycle();
        driveIdle();
        nextCycle();
        checks++; if (bus.result !== 64'd2) begin errors++; $display("[TB] FAIL first issue result: got %h expected 2", bus.result); end
        checks++; if (bus.res_makes_rd !== 1'b1) begin errors++; $display("[TB] FAIL first issue pulse: got %b expected 1", bus.res_makes_rd); end
    endtask

    task automatic test_add_sub();
        driveOp(3'd0, 1'b0, 1'b0, 5'd7, 1'b1, 64'd5, 64'd3, 32'd0, 1'b0);
        nextCycle();
        driveOp(3'd0, 1'b1, 1'b0, 5'd3, 1'b1, 64'd3, 64'd5, 32'd0, 1'b0);
        nextCycle();
        driveIdle();
        checks++; if (bus.result !== 64'd8) begin errors++; $display("[TB] FAIL add result: got %h expected 8", bus.result); end
        checks++; if (bus.res_rd !== 5'd7) begin errors++; $display("[TB] FAIL add res_rd: got %0d expected 7", bus.res_rd); end
        checks++; if (bus.res_makes_rd !== 1'b1) begin errors++; $display("[TB] FAIL add pulse: got %b expected 1", bus.res_makes_rd); end
        nextCycle();
        checks++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL sub result: got %h expected fffffffffffffffe", bus.result); end
        checks++; if (bus.res_rd !== 5'd3) begin errors++; $display("[TB] FAIL sub res_rd: got %0d expected 3", bus.res_rd); end
        checks++; if (bus.res_makes_rd !== 1'b1) begin errors++; $display("[TB] FAIL sub pulse: got %b expected 1", bus.res_makes_rd); end
        nextCycle();
        checks++; if (bus.res_makes_rd !== 1'b0) begin errors++; $display("[TB] FAIL idle pulse: got %b expected 0", bus.res_makes_rd); end
        checks++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL hold result: got %h expected fffffffffffffffe", bus.result); end
    endtask

    task automatic test_logic();
        driveOp(3'd1, 1'b0, 1'b0, 5'd11, 1'b1, 64'hF0F0, 64'h0FF0, 32'd0, 1'b0);
        nextCycle();
        driveOp(3'd2, 1'b0, 1'b0, 5'd12, 1'b0, 64'hFFFF_0000_1234_5678, 64'd0, 32'hFFFF_FF00, 1'b0);
        nextCycle();
        driveOp(3'd3, 1'b0, 1'b0, 5'd13, 1'b1, 64'h1, 64'h100, 32'd0, 1'b0);
        checks++; if (bus.result !== 64'hFF00) begin errors++; $display("[TB] FAIL xor result: got %h expected ff00", bus.result); end
        nextCycle();
        driveIdle();
        checks++; if (bus.result !== 64'hFFFF_0000_1234_5600) begin errors++; $display("[TB] FAIL and-immed result: got %h expected ffff000012345600", bus.result); end
        checks++; if (bus.res_rd !== 5'd12) begin errors++; $display("[TB] FAIL and res_rd: got %0d expected 12", bus.res_rd); end
        nextCycle();
        checks++; if (bus.result !== 64'h101) begin errors++; $display("[TB] FAIL or result: got %h expected 101", bus.result); end
        nextCycle();
    endtask

    task automatic test_compare();
        driveOp(3'd4, 1'b1, 1'b0, 5'd20, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 1'b0);
        nextCycle();
        driveOp(3'd5, 1'b1, 1'b0, 5'd21, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd0, 1'b0);
        nextCycle();
        driveOp(3'd4, 1'b1, 1'b0, 5'd22, 1'b1, 64'h8000_0000_0000_0000, 64'd1, 32'd0, 1'b0);
        checks++; if (bus.result !== 64'd1) begin errors++; $display("[TB] FAIL slt result: got %h expected 1", bus.result); end
        nextCycle();
        driveOp(3'd4, 1'b1, 1'b0, 5'd23, 1'b1, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0);
        checks++; if (bus.result !== 64'd0) begin errors++; $display("[TB] FAIL sltu result: got %h expected 0", bus.result); end
        nextCycle();
        driveIdle();
        checks++; if (bus.result !== 64'd1) begin errors++; $display("[TB] FAIL slt overflow result: got %h expected 1", bus.result); end
        nextCycle();
        checks++; if (bus.result !== 64'd0) begin errors++; $display("[TB] FAIL slt positive result: got %h expected 0", bus.result); end
        checks++; if (bus.res_rd !== 5'd23) begin errors++; $display("[TB] FAIL slt res_rd: got %0d expected 23", bus.res_rd); end
        nextCycle();
    endtask

    task automatic test_addw();
        driveOp(3'd0, 1'b0, 1'b1, 5'd5, 1'b0, 64'h7FFF_FFFF, 64'd0, 32'd1, 1'b0);
        nextCycle();
        driveOp(3'd0, 1'b0, 1'b1, 5'd6, 1'b0, 64'h1234_5678_0000_0001, 64'd0, 32'd2, 1'b0);
        nextCycle();
        driveIdle();
        checks++; if (bus.result !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("[TB] FAIL addw negative: got %h expected ffffffff80000000", bus.result); end
        nextCycle();
        checks++; if (bus.result !== 64'd3) begin errors++; $display("[TB] FAIL addw positive: got %h expected 3", bus.result); end
        nextCycle();
    endtask

    task automatic test_clmul();
        driveOp(3'd6, 1'b0, 1'b0, 5'd9, 1'b1, 64'd3, 64'd3, 32'd0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            nextCycle();
            if (k == 1) driveIdle();
            if (k <= 9) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL clmul busy T+%0d: got %b expected 1", k, bus.busy); end
                checks++; if (bus.res_makes_rd !== 1'b0) begin errors++; $display("[TB] FAIL clmul early pulse T+%0d: got %b expected 0", k, bus.res_makes_rd); end
            end
            if (k == 10) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL clmul busy T+10: got %b expected 0", bus.busy); end
                checks++; if (bus.result !== 64'd5) begin errors++; $display("[TB] FAIL clmul result: got %h expected 5", bus.result); end
                checks++; if (bus.res_makes_rd !== 1'b1) begin errors++; $display("[TB] FAIL clmul pulse: got %b expected 1", bus.res_makes_rd); end
                checks++; if (bus.res_rd !== 5'd9) begin errors++; $display("[TB] FAIL clmul res_rd: got %0d expected 9", bus.res_rd); end
                driveOp(3'd0, 1'b0, 1'b0, 5'd2, 1'b1, 64'd10, 64'd20, 32'd0, 1'b0);
            end
            if (k == 11) begin
                driveIdle();
                checks++; if (bus.result !== 64'd5 || bus.res_makes_rd !== 1'b0) begin errors++; $display("[TB] FAIL b2b hold: got %h/%b expected 5/0", bus.result, bus.res_makes_rd); end
            end
            if (k == 12) begin
                checks++; if (bus.result !== 64'd30) begin errors++; $display("[TB] FAIL b2b add result: got %h expected 1e", bus.result); end
            end
        end
        nextCycle();
    endtask

    task automatic test_clmul_wide();
        // 0xFF * 0xFF carry-less -> 0x5555
        driveOp(3'd6, 1'b0, 1'b0, 5'd14, 1'b1, 64'hFF, 64'hFF, 32'd0, 1'b0);
        nextCycle();
        driveIdle();
        repeat (9) nextCycle();
        checks++; if (bus.result !== 64'h5555) begin errors++; $display("[TB] FAIL clmul ff result: got %h expected 5555", bus.result); end
        // all-ones * 2: high half is just the shifted-out bit
        driveOp(3'd7, 1'b0, 1'b0, 5'd15, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 32'd0, 1'b0);
        nextCycle();
        driveIdle();
        repeat (9) nextCycle();
        checks++; if (bus.result !== 64'd1) begin errors++; $display("[TB] FAIL clmulh carry-out result: got %h expected 1", bus.result); end
        driveOp(3'd7, 1'b0, 1'b0, 5'd16, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 32'd0, 1'b0);
        nextCycle();
        driveIdle();
        repeat (8) nextCycle();
        checks++; if (bus.res_makes_rd !== 1'b0) begin errors++; $display("[TB] FAIL clmulh early pulse T+9: got %b expected 0", bus.res_makes_rd); end
        nextCycle();
        checks++; if (bus.result !== 64'h4000_0000_0000_0000) begin errors++; $display("[TB] FAIL clmulh msb result: got %h expected 4000000000000000", bus.result); end
        checks++; if (bus.res_makes_rd !== 1'b1) begin errors++; $display("[TB] FAIL clmulh pulse: got %b expected 1", bus.res_makes_rd); end
        nextCycle();
    endtask

    task automatic test_rv32();
        driveOp(3'd7, 1'b0, 1'b0, 5'd17, 1'b1, 64'h8000_0000, 64'h8000_0000, 32'd0, 1'b1);
        nextCycle();
        driveIdle();
        repeat (4) nextCycle();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL rv32 busy T+5: got %b expected 1", bus.busy); end
        nextCycle();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rv32 busy T+6: got %b expected 0", bus.busy); end
        checks++; if (bus.result !== 64'h4000_0000) begin errors++; $display("[TB] FAIL rv32 clmulh result: got %h expected 40000000", bus.result); end
        checks++; if (bus.res_makes_rd !== 1'b1) begin errors++; $display("[TB] FAIL rv32 clmulh pulse: got %b expected 1", bus.res_makes_rd); end
        // Upper operand bits ignored, bit 31 of the product sign-extends.
        driveOp(3'd6, 1'b0, 1'b0, 5'd18, 1'b1, 64'hABCD_0000_8000_0000, 64'hFFFF_0000_0000_0001, 32'd0, 1'b1);
        nextCycle();
        driveIdle();
        repeat (5) nextCycle();
        checks++; if (bus.result !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("[TB] FAIL rv32 clmul sext: got %h expected ffffffff80000000", bus.result); end
        nextCycle();
    endtask

    task automatic test_kill();
        driveOp(3'd0, 1'b0, 1'b0, 5'd1, 1'b1, 64'h55, 64'd0, 32'd0, 1'b0);
        nextCycle();
        driveIdle();
        nextCycle();
        checks++; if (bus.result !== 64'h55) begin errors++; $display("[TB] FAIL kill setup result: got %h expected 55", bus.result); end
        driveOp(3'd6, 1'b0, 1'b0, 5'd4, 1'b1, 64'd3, 64'd3, 32'd0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            nextCycle();
            if (k == 1) driveIdle();
            if (k == 4) bus.commit_kill[4] = 1'b1;
            if (k == 5) bus.commit_kill[4] = 1'b0;
            checks++; if (bus.res_makes_rd !== 1'b0) begin errors++; $display("[TB] FAIL killed pulse T+%0d: got %b expected 0", k, bus.res_makes_rd); end
            if (k == 4) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL kill busy T+4: got %b expected 1", bus.busy); end
            end
            if (k == 5) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL kill busy T+5: got %b expected 0", bus.busy); end
            end
        end
        checks++; if (bus.result !== 64'h55) begin errors++; $display("[TB] FAIL killed result held: got %h expected 55", bus.result); end
        // Single-cycle kill at T+1, then an unrelated tag is unaffected.
        driveOp(3'd0, 1'b0, 1'b0, 5'd6, 1'b1, 64'd40, 64'd2, 32'd0, 1'b0);
        nextCycle();
        driveOp(3'd0, 1'b0, 1'b0, 5'd8, 1'b1, 64'd70, 64'd7, 32'd0, 1'b0);
        bus.commit_kill[6] = 1'b1;
        nextCycle();
        driveIdle();
        bus.commit_kill[6] = 1'b0;
        bus.commit_kill[9] = 1'b1;
        checks++; if (bus.res_makes_rd !== 1'b0 || bus.result !== 64'h55) begin errors++; $display("[TB] FAIL single kill: got %b/%h expected 0/55", bus.res_makes_rd, bus.result); end
        nextCycle();
        bus.commit_kill[9] = 1'b0;
        checks++; if (bus.res_makes_rd !== 1'b1 || bus.result !== 64'd77) begin errors++; $display("[TB] FAIL other tag: got %b/%h expected 1/4d", bus.res_makes_rd, bus.result); end
        nextCycle();
    endtask

    task automatic test_reset_mid();
        driveOp(3'd6, 1'b0, 1'b0, 5'd19, 1'b1, 64'd3, 64'd3, 32'd0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            nextCycle();
            if (k == 1) driveIdle();
            if (k == 3) reset = 1'b0;
            if (k == 4) begin
                reset = 1'b1;
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mid reset busy: got %b expected 0", bus.busy); end
                checks++; if (bus.result !== 64'd0) begin errors++; $display("[TB] FAIL mid reset result: got %h expected 0", bus.result); end
                checks++; if (bus.res_rd !== 5'd0) begin errors++; $display("[TB] FAIL mid reset res_rd: got %0d expected 0", bus.res_rd); end
            end
            if (k == 5) driveOp(3'd0, 1'b0, 1'b0, 5'd2, 1'b1, 64'd7, 64'd8, 32'd0, 1'b0);
            if (k == 6) driveIdle();
            if (k == 7) begin
                checks++; if (bus.result !== 64'd15 || bus.res_makes_rd !== 1'b1) begin errors++; $display("[TB] FAIL post reset add: got %h/%b expected f/1", bus.result, bus.res_makes_rd); end
            end else begin
                checks++; if (bus.res_makes_rd !== 1'b0) begin errors++; $display("[TB] FAIL stray pulse T+%0d: got %b expected 0", k, bus.res_makes_rd); end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_sub();
        test_logic();
        test_compare();
        test_addw();
        test_clmul();
        test_clmul_wide();
        test_rv32();
        test_kill();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
